// File: rtl/key_onehot_capture.sv
// Debounced single-key capture: synchronizes eight raw key lines, accepts one stable
// one-hot press, holds it for a downstream encoder until acknowledged, then waits for full release.
module key_onehot_capture #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       ack,
    output logic [7:0] out,
    output logic       en,
    output logic       err,
    output logic       busy
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        VALID,
        RELEASE
    } state_t;

    state_t     state_reg;
    logic [7:0] key_meta_reg;
    logic [7:0] key_sync_reg;
    logic [7:0] cand_reg;
    logic [7:0] cnt_reg;
    logic [7:0] out_reg;
    logic       en_reg;
    logic       err_reg;
    logic       cand_onehot;
    logic       cnt_at_last;

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign cand_onehot = (cand_reg != 8'd0) && ((cand_reg & (cand_reg - 8'd1)) == 8'd0);
    assign cnt_at_last = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            key_meta_reg <= 8'd0;
            key_sync_reg <= 8'd0;
            cand_reg     <= 8'd0;
            cnt_reg      <= 8'd0;
            out_reg      <= 8'd0;
            en_reg       <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            key_meta_reg <= key;
            key_sync_reg <= key_meta_reg;
            err_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (key_sync_reg != 8'd0) begin
                        state_reg <= DEBOUNCE;
                        cand_reg  <= key_sync_reg;
                        cnt_reg   <= 8'd1;
                    end
                end
                DEBOUNCE: begin
                    if (key_sync_reg == 8'd0) begin
                        state_reg <= IDLE;
                    end else if (key_sync_reg != cand_reg) begin
                        // A different key pattern restarts the stability count.
                        cand_reg <= key_sync_reg;
                        cnt_reg  <= 8'd1;
                    end else if (cnt_at_last) begin
                        if (cand_onehot) begin
                            state_reg <= VALID;
                            out_reg   <= cand_reg;
                            en_reg    <= 1'b1;
                        end else begin
                            state_reg <= RELEASE;
                            cnt_reg   <= 8'd0;
                            err_reg   <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                VALID: begin
                    if (ack) begin
                        state_reg <= RELEASE;
                        out_reg   <= 8'd0;
                        en_reg    <= 1'b0;
                        cnt_reg   <= 8'd0;
                    end
                end
                RELEASE: begin
                    // Any key activity restarts the release count; only a full quiet run returns to IDLE.
                    if (key_sync_reg != 8'd0) begin
                        cnt_reg <= 8'd0;
                    end else if (cnt_at_last) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_reg;
    assign en   = en_reg;
    assign err  = err_reg;
    assign busy = (state_reg != IDLE);

endmodule
